// File: rtl/rom_arbiter_pkg.sv
// Shared definitions for the instruction-ROM arbiter: widths, FSM states and
// the owner encoding used by the round-robin pointer.
package rom_arbiter_pkg;

   localparam int ADDR_W = 6;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 16;

   // Which requester owned the access issued last cycle.
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RESP_IF  = 2'd1,
      ST_RESP_DBG = 2'd2
   } state_t;

   // Last-owner pointer encoding.
   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_DBG = 1'b1
   } owner_t;

endpackage

// File: rtl/rom_arbiter_if.sv
// Bundle of the fetch, debug and ROM-side signals around the arbiter.
// master: the surrounding system (requesters and ROM); slave: the arbiter.
interface rom_arbiter_if;
   import rom_arbiter_pkg::*;

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   logic              dbg_req;
   logic [ADDR_W-1:0] dbg_addr;
   logic              dbg_gnt;
   logic              dbg_rvalid;
   logic [DATA_W-1:0] dbg_rdata;

   logic              rom_ce;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_inst;

   logic [CNT_W-1:0]  conflict_cnt;

   modport master (
      output if_req, if_addr, dbg_req, dbg_addr, rom_inst,
      input  if_gnt, if_rvalid, if_rdata,
      input  dbg_gnt, dbg_rvalid, dbg_rdata,
      input  rom_ce, rom_addr, conflict_cnt
   );

   modport slave (
      input  if_req, if_addr, dbg_req, dbg_addr, rom_inst,
      output if_gnt, if_rvalid, if_rdata,
      output dbg_gnt, dbg_rvalid, dbg_rdata,
      output rom_ce, rom_addr, conflict_cnt
   );

endinterface

// File: rtl/rom_arbiter_rr_arb2.sv
// Two-way round-robin grant logic. On a conflict the requester that did not
// own the most recent grant wins; the pointer only moves when a grant issues.
module rr_arb2
   import rom_arbiter_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req_if,
   input  logic req_dbg,
   output logic gnt_if,
   output logic gnt_dbg
);

   owner_t last_owner_r;
   logic   gnt_if_s;
   logic   gnt_dbg_s;

   // Combinational grant: sole requester wins, conflict resolved by pointer.
   always_comb begin
      gnt_if_s  = 1'b0;
      gnt_dbg_s = 1'b0;
      if (req_if && req_dbg) begin
         if (last_owner_r == OWN_DBG) begin
            gnt_if_s = 1'b1;
         end else begin
            gnt_dbg_s = 1'b1;
         end
      end else if (req_if) begin
         gnt_if_s = 1'b1;
      end else if (req_dbg) begin
         gnt_dbg_s = 1'b1;
      end else begin
         gnt_if_s  = 1'b0;
         gnt_dbg_s = 1'b0;
      end
   end

   // Last-owner pointer; resets to debug so fetch wins the first conflict.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_owner_r <= OWN_DBG;
      end else if (gnt_if_s) begin
         last_owner_r <= OWN_IF;
      end else if (gnt_dbg_s) begin
         last_owner_r <= OWN_DBG;
      end else begin
         last_owner_r <= last_owner_r;
      end
   end

   assign gnt_if  = gnt_if_s;
   assign gnt_dbg = gnt_dbg_s;

endmodule

// File: rtl/rom_arbiter.sv
// Shares the single-port instruction ROM between instruction fetch and the
// debug/loader port. Grants are combinational, read data returns one cycle
// after the grant edge in the owning requester's registered rdata.
module rom_arbiter
   import rom_arbiter_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   rom_arbiter_if.slave bus
);

   logic              gnt_if_s;
   logic              gnt_dbg_s;
   logic              rom_ce_s;
   logic [ADDR_W-1:0] rom_addr_s;
   state_t            state_r;
   state_t            state_next_s;
   logic              if_rvalid_s;
   logic              dbg_rvalid_s;
   logic [DATA_W-1:0] if_rdata_r;
   logic [DATA_W-1:0] dbg_rdata_r;
   logic [CNT_W-1:0]  conflict_cnt_r;
   logic              conflict_s;

   rr_arb2 u_rr_arb2 (
      .clk     (clk),
      .rst     (rst),
      .req_if  (bus.if_req),
      .req_dbg (bus.dbg_req),
      .gnt_if  (gnt_if_s),
      .gnt_dbg (gnt_dbg_s)
   );

   // ROM address mux: idle bus parks at address zero with chip enable low.
   always_comb begin
      rom_ce_s   = 1'b0;
      rom_addr_s = {ADDR_W{1'b0}};
      if (gnt_if_s) begin
         rom_ce_s   = 1'b1;
         rom_addr_s = bus.if_addr;
      end else if (gnt_dbg_s) begin
         rom_ce_s   = 1'b1;
         rom_addr_s = bus.dbg_addr;
      end else begin
         rom_ce_s   = 1'b0;
         rom_addr_s = {ADDR_W{1'b0}};
      end
   end

   // Response FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next state is simply whichever access is issued this cycle.
   always_comb begin
      state_next_s = ST_IDLE;
      if (gnt_if_s) begin
         state_next_s = ST_RESP_IF;
      end else if (gnt_dbg_s) begin
         state_next_s = ST_RESP_DBG;
      end else begin
         state_next_s = ST_IDLE;
      end
   end

   // Decode rvalid for the requester that owned last cycle's access.
   always_comb begin
      if_rvalid_s  = 1'b0;
      dbg_rvalid_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if_rvalid_s  = 1'b0;
            dbg_rvalid_s = 1'b0;
         end
         ST_RESP_IF: begin
            if_rvalid_s  = 1'b1;
         end
         ST_RESP_DBG: begin
            dbg_rvalid_s = 1'b1;
         end
         default: begin
            if_rvalid_s  = 1'b0;
            dbg_rvalid_s = 1'b0;
         end
      endcase
   end

   // Capture ROM data into the granted requester's register; hold otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_rdata_r  <= {DATA_W{1'b0}};
         dbg_rdata_r <= {DATA_W{1'b0}};
      end else if (gnt_if_s) begin
         if_rdata_r  <= bus.rom_inst;
      end else if (gnt_dbg_s) begin
         dbg_rdata_r <= bus.rom_inst;
      end else begin
         if_rdata_r  <= if_rdata_r;
         dbg_rdata_r <= dbg_rdata_r;
      end
   end

   assign conflict_s = bus.if_req & bus.dbg_req;

   // Saturating count of cycles where both sides wanted the ROM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conflict_cnt_r <= {CNT_W{1'b0}};
      end else if (conflict_s && (conflict_cnt_r != {CNT_W{1'b1}})) begin
         conflict_cnt_r <= conflict_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         conflict_cnt_r <= conflict_cnt_r;
      end
   end

   assign bus.if_gnt       = gnt_if_s;
   assign bus.dbg_gnt      = gnt_dbg_s;
   assign bus.rom_ce       = rom_ce_s;
   assign bus.rom_addr     = rom_addr_s;
   assign bus.if_rvalid    = if_rvalid_s;
   assign bus.dbg_rvalid   = dbg_rvalid_s;
   assign bus.if_rdata     = if_rdata_r;
   assign bus.dbg_rdata    = dbg_rdata_r;
   assign bus.conflict_cnt = conflict_cnt_r;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: a behavioural ROM answers rom_addr, and
// each step compares outputs against hand-derived expectations.
module tb_rom_arbiter;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic [31:0] exp_if_data;
   logic [31:0] exp_dbg_data;
   int   n_if;
   int   n_dbg;

   rom_arbiter_if bus ();

   rom_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ROM contents: each word is derived from its address so every word differs.
   function automatic logic [31:0] rom_word(input logic [5:0] a);
      return {a, 2'b00, 8'h5A, a, 2'b11, 8'hC3};
   endfunction

   // Behavioural ROM, combinational on address and chip enable.
   always_comb begin
      if (bus.rom_ce) begin
         bus.rom_inst = rom_word(bus.rom_addr);
      end else begin
         bus.rom_inst = 32'h0000_0000;
      end
   end

   initial clk = 1'b0;
   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Change inputs on the falling edge, then let combinational paths settle.
   task automatic drive(input logic ir, input logic [5:0] ia, input logic dr, input logic [5:0] da);
      @(negedge clk);
      bus.if_req   = ir;
      bus.if_addr  = ia;
      bus.dbg_req  = dr;
      bus.dbg_addr = da;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst          = 1'b1;
      bus.if_req   = 1'b0;
      bus.dbg_req  = 1'b0;
      bus.if_addr  = 6'h00;
      bus.dbg_addr = 6'h00;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      n_if   = 0;
      n_dbg  = 0;
      rst          = 1'b1;
      bus.if_req   = 1'b0;
      bus.if_addr  = 6'h00;
      bus.dbg_req  = 1'b0;
      bus.dbg_addr = 6'h00;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      chk1 ("rst_if_rvalid",  bus.if_rvalid, 1'b0);
      chk1 ("rst_dbg_rvalid", bus.dbg_rvalid, 1'b0);
      chk32("rst_if_rdata",   bus.if_rdata, 32'h0);
      chk32("rst_dbg_rdata",  bus.dbg_rdata, 32'h0);
      chk32("rst_cnt",        {16'h0, bus.conflict_cnt}, 32'h0);
      chk1 ("rst_rom_ce",     bus.rom_ce, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Back-to-back fetch from addresses 0..5
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 6'(i), 1'b0, 6'h00);
         chk1 ("seq_if_gnt",   bus.if_gnt, 1'b1);
         chk1 ("seq_dbg_gnt",  bus.dbg_gnt, 1'b0);
         chk32("seq_rom_addr", {26'h0, bus.rom_addr}, 32'(i));
         if (i == 0) chk1("seq_if_rvalid_first", bus.if_rvalid, 1'b0);
         else        chk1("seq_if_rvalid_cont",  bus.if_rvalid, 1'b1);
         tick();
         chk1 ("seq_if_rvalid", bus.if_rvalid, 1'b1);
         chk32("seq_if_rdata",  bus.if_rdata, rom_word(6'(i)));
      end

      // First conflict after reset goes to fetch, then debug
      do_reset();
      drive(1'b1, 6'h04, 1'b1, 6'h10);
      chk1 ("c1_if_gnt",  bus.if_gnt, 1'b1);
      chk1 ("c1_dbg_gnt", bus.dbg_gnt, 1'b0);
      chk32("c1_rom_addr", {26'h0, bus.rom_addr}, 32'h04);
      tick();
      chk1 ("c1_if_rvalid", bus.if_rvalid, 1'b1);
      chk32("c1_if_rdata",  bus.if_rdata, rom_word(6'h04));
      drive(1'b0, 6'h04, 1'b1, 6'h10);
      chk1 ("c2_dbg_gnt", bus.dbg_gnt, 1'b1);
      chk32("c2_rom_addr", {26'h0, bus.rom_addr}, 32'h10);
      tick();
      chk1 ("c2_dbg_rvalid", bus.dbg_rvalid, 1'b1);
      chk1 ("c2_if_rvalid",  bus.if_rvalid, 1'b0);
      chk32("c2_dbg_rdata",  bus.dbg_rdata, rom_word(6'h10));
      chk32("c2_if_rdata_hold", bus.if_rdata, rom_word(6'h04));
      chk32("c2_cnt", {16'h0, bus.conflict_cnt}, 32'd1);

      // Ten cycles of continuous conflict: strict alternation starting at fetch
      do_reset();
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 6'(20 + k), 1'b1, 6'(40 + k));
         chk1("alt_if_gnt",  bus.if_gnt,  (k % 2) == 0);
         chk1("alt_dbg_gnt", bus.dbg_gnt, (k % 2) == 1);
         if (bus.if_gnt)  n_if++;
         if (bus.dbg_gnt) n_dbg++;
         if ((k % 2) == 0) exp_if_data  = rom_word(6'(20 + k));
         else              exp_dbg_data = rom_word(6'(40 + k));
         tick();
         chk1("alt_if_rvalid",  bus.if_rvalid,  (k % 2) == 0);
         chk1("alt_dbg_rvalid", bus.dbg_rvalid, (k % 2) == 1);
         if ((k % 2) == 0) chk32("alt_if_rdata",  bus.if_rdata,  exp_if_data);
         else              chk32("alt_dbg_rdata", bus.dbg_rdata, exp_dbg_data);
      end
      chk32("alt_n_if",  32'(n_if),  32'd5);
      chk32("alt_n_dbg", 32'(n_dbg), 32'd5);
      chk32("alt_cnt", {16'h0, bus.conflict_cnt}, 32'd10);

      // No requests: bus parks, rvalids drop, data registers hold
      drive(1'b0, 6'h3F, 1'b0, 6'h2A);
      chk1 ("idle_rom_ce",   bus.rom_ce, 1'b0);
      chk32("idle_rom_addr", {26'h0, bus.rom_addr}, 32'h0);
      chk1 ("idle_if_gnt",   bus.if_gnt, 1'b0);
      chk1 ("idle_dbg_gnt",  bus.dbg_gnt, 1'b0);
      tick();
      chk1 ("idle_if_rvalid",  bus.if_rvalid, 1'b0);
      chk1 ("idle_dbg_rvalid", bus.dbg_rvalid, 1'b0);
      chk32("idle_if_rdata",   bus.if_rdata, rom_word(6'd28));
      chk32("idle_dbg_rdata",  bus.dbg_rdata, rom_word(6'd49));
      chk32("idle_cnt", {16'h0, bus.conflict_cnt}, 32'd10);

      // Reset asserted during a debug grant
      drive(1'b0, 6'h00, 1'b1, 6'h08);
      chk1 ("rg_dbg_gnt", bus.dbg_gnt, 1'b1);
      chk32("rg_rom_addr", {26'h0, bus.rom_addr}, 32'h08);
      rst = 1'b1;
      #1;
      chk32("rg_cnt_async", {16'h0, bus.conflict_cnt}, 32'h0);
      chk32("rg_if_rdata_async", bus.if_rdata, 32'h0);
      tick();
      chk1 ("rg_dbg_rvalid", bus.dbg_rvalid, 1'b0);
      chk1 ("rg_if_rvalid",  bus.if_rvalid, 1'b0);
      chk32("rg_dbg_rdata",  bus.dbg_rdata, 32'h0);
      chk32("rg_if_rdata",   bus.if_rdata, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 6'h01, 1'b1, 6'h02);
      chk1("rg_next_if_gnt",  bus.if_gnt, 1'b1);
      chk1("rg_next_dbg_gnt", bus.dbg_gnt, 1'b0);
      tick();
      chk32("rg_next_cnt", {16'h0, bus.conflict_cnt}, 32'd1);

      // Counter saturation
      do_reset();
      drive(1'b1, 6'h03, 1'b1, 6'h07);
      repeat (65534) @(posedge clk);
      #1;
      chk32("sat_fffe", {16'h0, bus.conflict_cnt}, 32'h0000_FFFE);
      repeat (2) @(posedge clk);
      #1;
      chk32("sat_ffff", {16'h0, bus.conflict_cnt}, 32'h0000_FFFF);
      tick();
      chk32("sat_hold", {16'h0, bus.conflict_cnt}, 32'h0000_FFFF);
      drive(1'b0, 6'h00, 1'b0, 6'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-requester arbiter that shares the single-port instruction ROM between the instruction-fetch path (PC register) and a debug/loader read port. It sits between the PC register, the debug port and the ROM, drives the ROM chip-enable and address, and returns registered read data to whichever requester owned the access. Arbitration is round-robin, so fetch cannot starve debug and debug cannot stall fetch indefinitely.

## Interface
- ADDR_W, 6, ROM word-address width (matches PC width)
- DATA_W, 32, instruction/data word width
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch requests a read this cycle
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  fetch access issued this cycle (combinational)
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_W  fetch read data
- dbg_req  in  1  debug requests a read
- dbg_addr  in  ADDR_W  debug word address
- dbg_gnt  out  1  debug access issued this cycle (combinational)
- dbg_rvalid  out  1  debug read data valid
- dbg_rdata  out  DATA_W  debug read data
- rom_ce  out  1  ROM chip enable
- rom_addr  out  ADDR_W  ROM address
- rom_inst  in  DATA_W  ROM read data (combinational w.r.t. rom_addr/rom_ce)
- conflict_cnt  out  16  count of cycles with both requests high, saturating

## Operation
- Requester holds req high and addr stable until it sees gnt high at a rising edge; the access completes at that edge.
- At most one grant per cycle. Only one req high: that requester is granted. Both high: grant goes to the requester not granted most recently (last-owner pointer). Neither high: no grant, rom_ce=0, rom_addr=0.
- Last-owner pointer: 1 bit, updated only on a grant; reset value = debug (so fetch wins the first conflict after reset).
- Granted requester's addr drives rom_addr, rom_ce=1, same cycle.
- At the grant edge, rom_inst is captured into that requester's rdata register; its rvalid is high for exactly the following cycle. rdata holds its value until the next capture for that requester.
- Back-to-back: a sole requester may be granted every cycle; rvalid then stays high continuously with new data each cycle.
- Both requesting continuously: grants alternate IF, DBG, IF, DBG...; each side gets one access per two cycles.
- conflict_cnt increments on every cycle with if_req & dbg_req; saturates at 16'hFFFF.
- Owner/rvalid tracking is a three-state FSM: IDLE (no access last cycle), RESP_IF, RESP_DBG; next state = grant issued this cycle, IDLE if none.

## Timing
- Grant latency: 0 cycles (combinational from req and pointer).
- Read latency: data/rvalid 1 cycle after grant edge.
- Reset (asynchronous, any time): FSM=IDLE, pointer=debug, if_rvalid=dbg_rvalid=0, if_rdata=dbg_rdata=0, conflict_cnt=0. Combinational outputs follow inputs immediately after reset release. An access granted in the cycle reset asserts yields no rvalid.
- Requester dropping req without a grant: legal, no side effect.

## Structure
- Shared package: ADDR_W/DATA_W defaults, FSM state encoding (IDLE, RESP_IF, RESP_DBG), owner encoding (OWN_IF=0, OWN_DBG=1).
- One sub-module: rr_arb2 — 2-way round-robin grant logic with last-owner pointer register; top level holds address mux, data capture, FSM and counter.

## Test plan
- Reset then if_req=1, if_addr=6'h00..6'h05 each cycle, dbg_req=0 -> if_gnt every cycle, if_rvalid from cycle 2 onward, if_rdata = ROM[0..5] in order.
- First conflict after reset: if_req=dbg_req=1, if_addr=6'h04, dbg_addr=6'h10 -> cycle 1 if_gnt, cycle 2 dbg_gnt; if_rdata=ROM[4], dbg_rdata=ROM[16] one cycle after each grant.
- Both requesting for 10 cycles -> 5 grants each, strictly alternating; conflict_cnt=10.
- No requests -> rom_ce=0, rom_addr=0, both rvalid=0 after one cycle; rdata registers unchanged.
- Assert rst in the cycle of a dbg grant (addr 6'h08) -> dbg_rvalid stays 0, all outputs at reset values, next conflict granted to fetch.
- Force conflict_cnt to 16'hFFFE, two conflict cycles -> holds 16'hFFFF.
